// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - requester, grant and output stream bundle for mux_arbiter
interface mux_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       xfer_cnt_a;
    logic [15:0]       xfer_cnt_b;

    modport master (
        input  req_a, data_a, req_b, data_b, out_ready,
        output gnt_a, gnt_b, sel, out_data, out_valid, xfer_cnt_a, xfer_cnt_b
    );

    modport slave (
        output req_a, data_a, req_b, data_b, out_ready,
        input  gnt_a, gnt_b, sel, out_data, out_valid, xfer_cnt_a, xfer_cnt_b
    );
endinterface

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin burst arbiter for a 2:1 data mux (MUX_ARB_STATS_EN adds transfer counters)
module mux_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_arbiter_if.master bus
);
    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              last_srv, last_srv_nxt;
    logic              sel_q, sel_nxt;
    logic              gnt_a_q, gnt_b_q;
    logic              cur_req, oth_req, grant_end, xfer;
    logic [DATA_W-1:0] data_sel;

    assign data_sel      = sel_q ? bus.data_b : bus.data_a;
    assign bus.out_data  = data_sel;
    assign bus.out_valid = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);
    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.sel       = sel_q;
    assign xfer          = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_srv <= 1'b1;
            sel_q    <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last_srv <= last_srv_nxt;
            sel_q    <= sel_nxt;
            gnt_a_q  <= (state_nxt == GRANT_A);
            gnt_b_q  <= (state_nxt == GRANT_B);
        end
    end

    always_comb begin
        state_nxt    = state;
        last_srv_nxt = last_srv;
        cur_req      = 1'b0;
        oth_req      = 1'b0;
        grant_end    = 1'b0;
        case (state)
            IDLE: begin
                // last_srv = 1 means B was served last, so A wins a tie
                if (bus.req_a && (!bus.req_b || last_srv)) begin
                    state_nxt = GRANT_A;
                end else if (bus.req_b) begin
                    state_nxt = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                cur_req   = (state == GRANT_A) ? bus.req_a : bus.req_b;
                oth_req   = (state == GRANT_A) ? bus.req_b : bus.req_a;
                grant_end = !cur_req || (xfer && (hold_cnt == HOLD_LAST));
                if (grant_end) begin
                    last_srv_nxt = (state == GRANT_B);
                    if (oth_req) begin
                        state_nxt = (state == GRANT_A) ? GRANT_B : GRANT_A;
                    end else if (cur_req) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // a same-requester re-grant still starts a fresh burst
        hold_cnt_nxt = hold_cnt;
        if (grant_end || (state_nxt != state)) begin
            hold_cnt_nxt = '0;
        end else if (xfer) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end

        case (state_nxt)
            GRANT_A: sel_nxt = 1'b0;
            GRANT_B: sel_nxt = 1'b1;
            default: sel_nxt = sel_q;
        endcase
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] cnt_a, cnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (xfer && gnt_a_q) cnt_a <= cnt_a + 16'd1;
            if (xfer && gnt_b_q) cnt_b <= cnt_b + 16'd1;
        end
    end

    assign bus.xfer_cnt_a = cnt_a;
    assign bus.xfer_cnt_b = cnt_b;
`else
    assign bus.xfer_cnt_a = 16'd0;
    assign bus.xfer_cnt_b = 16'd0;
`endif
endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - randomized reference-model bench for mux_arbiter (MAX_HOLD 4 and 1 side by side)
module tb_mux_arbiter;
    localparam int DW  = 8;
    localparam int MH0 = 4;
    localparam int MH1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_arbiter_if #(.DATA_W(DW)) bus0 ();
    mux_arbiter_if #(.DATA_W(DW)) bus1 ();

    mux_arbiter #(.DATA_W(DW), .MAX_HOLD(MH0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mux_arbiter #(.DATA_W(DW), .MAX_HOLD(MH1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic          req_a_d [2];
    logic          req_b_d [2];
    logic          rdy_d   [2];
    logic [DW-1:0] da      [2];
    logic [DW-1:0] db      [2];
    logic          ga      [2];
    logic          gb      [2];
    logic          sl      [2];
    logic          ov      [2];
    logic [DW-1:0] od      [2];
    logic [15:0]   ca      [2];
    logic [15:0]   cb      [2];

    assign bus0.req_a = req_a_d[0];  assign bus1.req_a = req_a_d[1];
    assign bus0.req_b = req_b_d[0];  assign bus1.req_b = req_b_d[1];
    assign bus0.data_a = da[0];      assign bus1.data_a = da[1];
    assign bus0.data_b = db[0];      assign bus1.data_b = db[1];
    assign bus0.out_ready = rdy_d[0]; assign bus1.out_ready = rdy_d[1];
    assign ga[0] = bus0.gnt_a;       assign ga[1] = bus1.gnt_a;
    assign gb[0] = bus0.gnt_b;       assign gb[1] = bus1.gnt_b;
    assign sl[0] = bus0.sel;         assign sl[1] = bus1.sel;
    assign ov[0] = bus0.out_valid;   assign ov[1] = bus1.out_valid;
    assign od[0] = bus0.out_data;    assign od[1] = bus1.out_data;
    assign ca[0] = bus0.xfer_cnt_a;  assign ca[1] = bus1.xfer_cnt_a;
    assign cb[0] = bus0.xfer_cnt_b;  assign cb[1] = bus1.xfer_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // owner: 0 none, 1 A, 2 B; last: who finished a grant most recently
    int            max_hold [2];
    int            owner    [2];
    int            done     [2];
    int            last     [2];
    int            exp_sel  [2];
    int            rem_a    [2];
    int            rem_b    [2];
    int            tot_a    [2];
    int            tot_b    [2];
    logic [DW-1:0] seq_a    [2];
    logic [DW-1:0] seq_b    [2];
    int            rdy_mode;
    int            reload_en;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int stat_exp(input int v);
`ifdef MUX_ARB_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_reset(input int k);
        owner[k]   = 0;
        done[k]    = 0;
        last[k]    = 2;
        exp_sel[k] = 0;
        tot_a[k]   = 0;
        tot_b[k]   = 0;
    endtask

    task automatic check_outputs(input int k);
        int ev;
        ev = (owner[k] == 1) ? int'(req_a_d[k]) : (owner[k] == 2) ? int'(req_b_d[k]) : 0;
        check($sformatf("u%0d_gnt_a", k), int'(ga[k]), int'(owner[k] == 1));
        check($sformatf("u%0d_gnt_b", k), int'(gb[k]), int'(owner[k] == 2));
        check($sformatf("u%0d_excl", k), int'(ga[k] & gb[k]), 0);
        check($sformatf("u%0d_sel", k), int'(sl[k]), exp_sel[k]);
        check($sformatf("u%0d_out_valid", k), int'(ov[k]), ev);
        if (ev != 0)
            check($sformatf("u%0d_out_data", k), int'(od[k]),
                  (owner[k] == 1) ? int'(seq_a[k]) : int'(seq_b[k]));
        check($sformatf("u%0d_cnt_a", k), int'(ca[k]), stat_exp(tot_a[k]));
        check($sformatf("u%0d_cnt_b", k), int'(cb[k]), stat_exp(tot_b[k]));
    endtask

    task automatic model_update(input int k);
        int ra, rb, my, oth, x, cnt, own_n;
        if (rst) begin
            model_reset(k);
            return;
        end
        ra  = int'(req_a_d[k]);
        rb  = int'(req_b_d[k]);
        my  = (owner[k] == 1) ? ra : (owner[k] == 2) ? rb : 0;
        oth = (owner[k] == 1) ? rb : ra;
        x   = my & int'(rdy_d[k]);
        if (x != 0) begin
            if (owner[k] == 1) begin
                seq_a[k] = seq_a[k] + 8'd1; rem_a[k]--; tot_a[k] = (tot_a[k] + 1) % 65536;
            end else begin
                seq_b[k] = seq_b[k] + 8'd1; rem_b[k]--; tot_b[k] = (tot_b[k] + 1) % 65536;
            end
        end
        if (owner[k] == 0) begin
            if (ra != 0 && rb != 0) own_n = (last[k] == 1) ? 2 : 1;
            else if (ra != 0)       own_n = 1;
            else if (rb != 0)       own_n = 2;
            else                    own_n = 0;
            done[k] = 0;
        end else begin
            cnt = done[k] + x;
            if (my == 0 || cnt == max_hold[k]) begin
                last[k] = owner[k];
                own_n   = (oth != 0) ? 3 - owner[k] : (my != 0) ? owner[k] : 0;
                done[k] = 0;
            end else begin
                own_n   = owner[k];
                done[k] = cnt;
            end
        end
        if (own_n != 0) exp_sel[k] = int'(own_n == 2);
        owner[k] = own_n;
        if (reload_en != 0) begin
            if (rem_a[k] == 0 && $urandom_range(0, 3) == 0) rem_a[k] = $urandom_range(1, 8);
            if (rem_b[k] == 0 && $urandom_range(0, 3) == 0) rem_b[k] = $urandom_range(1, 8);
        end
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) begin
            req_a_d[k] = (rem_a[k] > 0);
            req_b_d[k] = (rem_b[k] > 0);
            da[k]      = seq_a[k];
            db[k]      = seq_b[k];
            rdy_d[k]   = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
        for (int k = 0; k < 2; k++) model_update(k);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        max_hold[0] = MH0;
        max_hold[1] = MH1;
        reload_en   = 0;
        rdy_mode    = 1;
        for (int k = 0; k < 2; k++) begin
            rem_a[k]   = 0;
            rem_b[k]   = 0;
            seq_a[k]   = 8'($urandom_range(0, 255));
            seq_b[k]   = 8'h5A;
            req_a_d[k] = 1'b0;
            req_b_d[k] = 1'b0;
            rdy_d[k]   = 1'b0;
            da[k]      = '0;
            db[k]      = '0;
            model_reset(k);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset held with both requesting, then A must win the first tie
        for (int k = 0; k < 2; k++) begin rem_a[k] = 1000; rem_b[k] = 1000; end
        step();
        step();
        rst = 1'b0;
        repeat (40) step();

        // backpressure: grant frozen, then drains
        rdy_mode = 0;
        repeat (10) step();
        rdy_mode = 1;
        repeat (10) step();

        // single requester B bursts, then randomized traffic with occasional reset
        for (int k = 0; k < 2; k++) begin rem_a[k] = 0; rem_b[k] = 9; end
        repeat (14) step();
        reload_en = 1;
        rdy_mode  = 2;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        // stats: 300 A transfers then 5 B transfers after a reset
        reload_en = 0;
        rdy_mode  = 1;
        for (int k = 0; k < 2; k++) begin rem_a[k] = 300; rem_b[k] = 0; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        guard = 0;
        while ((rem_a[0] > 0 || rem_a[1] > 0) && guard < 800) begin step(); guard++; end
        check("stats_a_timeout", int'(guard < 800), 1);
        for (int k = 0; k < 2; k++) rem_b[k] = 5;
        guard = 0;
        while ((rem_b[0] > 0 || rem_b[1] > 0) && guard < 50) begin step(); guard++; end
        check("stats_b_timeout", int'(guard < 50), 1);
        step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d_stats_a_300", k), int'(ca[k]), stat_exp(300));
            check($sformatf("u%0d_stats_b_5", k), int'(cb[k]), stat_exp(5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter and sequencer for the shared 2:1 data multiplexer (select 0 passes input A, select 1 passes input B). It grants the mux to one requester at a time and drives the select line. It presents the selected data as a valid/ready stream to the downstream consumer. It limits each grant to a bounded burst, so neither requester can starve the other.

## Interface
Parameters:
- DATA_W, 8, width of each requester's data and of out_data
- MAX_HOLD, 4, maximum transfers per grant before the arbiter must re-arbitrate; legal range 1..255

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- req_a  in  1  requester A has data; held until its burst is done
- data_a  in  DATA_W  requester A data
- req_b  in  1  requester B has data
- data_b  in  DATA_W  requester B data
- gnt_a  out  1  A owns the mux (registered)
- gnt_b  out  1  B owns the mux (registered)
- sel  out  1  mux select: 0 = A, 1 = B (registered)
- out_data  out  DATA_W  mux output: sel ? data_b : data_a (combinational)
- out_valid  out  1  granted requester's req AND its grant
- out_ready  in  1  downstream accepts out_data
- xfer_cnt_a  out  16  transfers completed by A (see Configuration)
- xfer_cnt_b  out  16  transfers completed by B (see Configuration)

## Operation
- States: IDLE, GRANT_A, GRANT_B.
- Internal registers:
  - last_srv: 0 = A served last, 1 = B served last.
  - hold_cnt: width $clog2(MAX_HOLD+1).
- Transfer: out_valid & out_ready in the same cycle.
- IDLE:
  - gnt_a = gnt_b = 0; out_valid = 0; sel keeps its last value.
  - req_a only -> GRANT_A.
  - req_b only -> GRANT_B.
  - Both -> grant the requester opposite last_srv.
  - Neither -> stay in IDLE.
- GRANT_X:
  - gnt_X = 1; sel = X.
  - out_valid = req_X.
  - hold_cnt increments on each transfer.
- Grant ends when either:
  - (a) req_X = 0, or
  - (b) a transfer occurs with hold_cnt = MAX_HOLD-1.
- On grant end:
  - last_srv <= X.
  - Next state is GRANT_other if req_other = 1.
  - Otherwise GRANT_X if req_X = 1 (case b only).
  - Otherwise IDLE.
- hold_cnt clears to 0 on every state change and whenever a new grant starts, including a GRANT_X -> GRANT_X re-grant.
- Requester contract (not checked by the block):
  - Keep req asserted until granted.
  - Keep data stable while req & gnt & !out_ready.
  - Deassert req only in a cycle with no pending transfer.
- gnt_a and gnt_b are never both 1. sel changes only on a grant change.

## Timing
- Reset values: state IDLE, gnt_a = 0, gnt_b = 0, sel = 0, hold_cnt = 0, last_srv = 1 (A wins the first tie), out_valid = 0, xfer_cnt_a = xfer_cnt_b = 0.
- Grant latency: req sampled in IDLE -> gnt and sel valid the next cycle. This is 1 dead cycle per arbitration from IDLE.
- Direct handoff from GRANT_X to GRANT_other: zero bubble beyond the registered switch. The last transfer of X occurs in cycle n; other's grant starts in cycle n+1.
- out_data and out_valid are combinational from the inputs and the registered sel/gnt. There is no pipeline latency.
- Sustained throughput with both requesting and out_ready = 1: one transfer per cycle, alternating bursts of MAX_HOLD.
- MAX_HOLD = 1: the grant alternates after every transfer when both request.
- out_ready held low: the grant persists indefinitely and hold_cnt does not advance.
- Reset mid-burst: next cycle is IDLE, grants drop, and the in-flight transfer is abandoned.

## Configuration
- MUX_ARB_STATS_EN defined:
  - xfer_cnt_a and xfer_cnt_b increment by 1 on each transfer by A or B respectively.
  - They wrap at 16'hFFFF -> 0 and clear on rst.
- Not defined:
  - Both ports are present and tied to 0.
  - No counter flops are synthesized.
  - Arbitration behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles with both requests high -> gnt_a = gnt_b = 0, sel = 0, out_valid = 0. One cycle after rst falls -> gnt_a = 1, sel = 0.
- Single requester: req_b = 1, out_ready = 1, MAX_HOLD = 4, data_b = 8'h5A -> gnt_b and sel = 1 the next cycle, out_data = 8'h5A, out_valid = 1. After 4 transfers, one cycle of re-grant to B with hold_cnt = 0 and no IDLE visit.
- Tie round-robin: req_a = req_b = 1 continuously, out_ready = 1, MAX_HOLD = 4 -> first grant to A for 4 transfers, then B for 4, then A. gnt_a & gnt_b is never 1.
- Backpressure: during GRANT_A, out_ready = 0 for 10 cycles with req_b = 1 -> gnt_a held, hold_cnt frozen, out_data stable. Grant switches only after the remaining transfers complete.
- Early release: A granted, req_a drops after 2 transfers while req_b = 1 -> the next cycle gnt_b = 1, sel = 1, last_srv = A.
- Stats (MUX_ARB_STATS_EN): 300 A transfers and 5 B transfers -> xfer_cnt_a = 300, xfer_cnt_b = 5. Without the macro, both read 0.
